pid_ctrl_param: RTL and testbench

PID_CTRL_PARAM -- requirements
Module: pid_ctrl_param

---
 rtl/pid_pkg.sv | 40 ++++
 rtl/pid_sat.sv | 29 ++
 rtl/pid_ctrl_param.sv | 167 ++++++++++++++++
 tb/tb_pid_ctrl_param.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// pid_pkg: shared types and width helpers for the PID controller.
//   pid_state_t   - controller sequencing state
//   err_w         - signed error width (one sign bit over the data width)
//   prod_w        - width of any gain * error product (covers the derivative
//                   difference, which needs one bit more than the error)
//   icand_w       - width of integral + ki*error before saturation
//   sum_w         - width of p + i + d that cannot overflow
package pid_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ERR   = 3'd1,
        S_TERMS = 3'd2,
        S_SUM   = 3'd3,
        S_OUT   = 3'd4
    } pid_state_t;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int err_w(input int data_w);
        return data_w + 1;
    endfunction

    // signed gain is coef_w+1 bits, derivative difference is data_w+2 bits
    function automatic int prod_w(input int data_w, input int coef_w);
        return data_w + coef_w + 3;
    endfunction

    function automatic int icand_w(input int acc_w, input int p_w);
        return max_w(acc_w, p_w) + 1;
    endfunction

    // three terms summed: two guard bits over the widest operand
    function automatic int sum_w(input int acc_w, input int p_w);
        return max_w(acc_w, p_w) + 2;
    endfunction

endpackage

// File: rtl/pid_sat.sv
// pid_sat: signed saturator from IN_W bits down to OUT_W bits.
//   SYMMETRIC=1 : clamp to +/-(2^(OUT_W-1)-1), result is signed OUT_W bits
//   SYMMETRIC=0 : clamp to [0, 2^OUT_W-1],     result is unsigned OUT_W bits
// Ports:
//   din  in  IN_W  signed value to clamp (IN_W must exceed OUT_W)
//   dout out OUT_W clamped value
module pid_sat #(
    parameter int IN_W      = 16,
    parameter int OUT_W     = 8,
    parameter bit SYMMETRIC = 1'b1
) (
    input  logic signed [IN_W-1:0] din,
    output logic [OUT_W-1:0]       dout
);

    localparam logic signed [IN_W-1:0] ONE = {{(IN_W-1){1'b0}}, 1'b1};
    localparam logic signed [IN_W-1:0] HI  = SYMMETRIC ? ((ONE <<< (OUT_W-1)) - ONE)
                                                       : ((ONE <<< OUT_W) - ONE);
    localparam logic signed [IN_W-1:0] LO  = SYMMETRIC ? -HI : '0;

    always_comb begin
        dout = din[OUT_W-1:0];
        if (din > HI)
            dout = HI[OUT_W-1:0];
        else if (din < LO)
            dout = LO[OUT_W-1:0];
    end

endmodule

// File: rtl/pid_ctrl_param.sv
// pid_ctrl_param: sequential PID controller, one sample per five cycles.
// A sample is latched in IDLE, then ERR forms the error, TERMS forms the
// P, D and candidate integral terms, SUM adds and rescales them, OUT clamps
// to the output range and commits the integral (with anti-windup hold).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   sample_valid/ready  sample handshake (ready only while idle)
//   setpoint, feedback  unsigned DATA_W operands
//   kp, ki, kd          unsigned gains with FRAC_BITS fraction bits
//   clear_int           zero integral and previous error
//   control_out         clamped result, held between updates
//   out_valid           one-cycle pulse when control_out updates
//   saturated           last result was clamped
module pid_ctrl_param
    import pid_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int FRAC_BITS = 4,
    parameter int ACC_W     = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    output logic              sample_ready,
    input  logic [DATA_W-1:0] setpoint,
    input  logic [DATA_W-1:0] feedback,
    input  logic [COEF_W-1:0] kp,
    input  logic [COEF_W-1:0] ki,
    input  logic [COEF_W-1:0] kd,
    input  logic              clear_int,
    output logic [DATA_W-1:0] control_out,
    output logic              out_valid,
    output logic              saturated
);

    localparam int EW = err_w(DATA_W);
    localparam int PW = prod_w(DATA_W, COEF_W);
    localparam int IW = icand_w(ACC_W, PW);
    localparam int SW = sum_w(ACC_W, PW);

    pid_state_t               state;
    logic [DATA_W-1:0]        sp_r, fb_r;
    logic [COEF_W-1:0]        kp_r, ki_r, kd_r;
    logic signed [EW-1:0]     err_r, prev_err;
    logic signed [ACC_W-1:0]  integral, i_cand_r;
    logic signed [PW-1:0]     p_r, d_r;
    logic signed [SW-1:0]     sum_r;

    // ---- TERMS datapath: everything sign-extended to PW before multiplying
    logic signed [EW:0]       diff;
    logic signed [PW-1:0]     err_x, diff_x, kp_x, ki_x, kd_x;
    logic signed [PW-1:0]     p_x, i_x, d_x;
    logic signed [IW-1:0]     i_sum;
    logic [ACC_W-1:0]         i_sat;

    assign diff   = {err_r[EW-1], err_r} - {prev_err[EW-1], prev_err};
    assign err_x  = {{(PW-EW){err_r[EW-1]}}, err_r};
    assign diff_x = {{(PW-EW-1){diff[EW]}}, diff};
    assign kp_x   = {{(PW-COEF_W){1'b0}}, kp_r};
    assign ki_x   = {{(PW-COEF_W){1'b0}}, ki_r};
    assign kd_x   = {{(PW-COEF_W){1'b0}}, kd_r};
    assign p_x    = kp_x * err_x;
    assign i_x    = ki_x * err_x;
    assign d_x    = kd_x * diff_x;
    assign i_sum  = {{(IW-ACC_W){integral[ACC_W-1]}}, integral}
                  + {{(IW-PW){i_x[PW-1]}}, i_x};

    pid_sat #(.IN_W(IW), .OUT_W(ACC_W), .SYMMETRIC(1'b1)) u_int_sat (
        .din  (i_sum),
        .dout (i_sat)
    );

    // ---- SUM datapath
    logic signed [SW-1:0]     sum_full;
    assign sum_full = {{(SW-PW){p_r[PW-1]}}, p_r}
                    + {{(SW-PW){d_r[PW-1]}}, d_r}
                    + {{(SW-ACC_W){i_cand_r[ACC_W-1]}}, i_cand_r};

    // ---- OUT clamp
    logic [DATA_W-1:0]        out_clamped;
    logic                     clip_lo, clip_hi, err_pos, err_neg, hold_int;

    pid_sat #(.IN_W(SW), .OUT_W(DATA_W), .SYMMETRIC(1'b0)) u_out_sat (
        .din  (sum_r),
        .dout (out_clamped)
    );

    assign clip_lo  = sum_r[SW-1];
    assign clip_hi  = !sum_r[SW-1] && (|sum_r[SW-2:DATA_W]);
    assign err_neg  = err_r[EW-1];
    assign err_pos  = !err_r[EW-1] && (|err_r);
    // Integrating further in the direction that is already clamped only
    // stores windup, so the integral is frozen in that case.
    assign hold_int = (clip_hi && err_pos) || (clip_lo && err_neg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            sample_ready <= 1'b1;
            out_valid    <= 1'b0;
            saturated    <= 1'b0;
            control_out  <= '0;
            sp_r         <= '0;
            fb_r         <= '0;
            kp_r         <= '0;
            ki_r         <= '0;
            kd_r         <= '0;
            err_r        <= '0;
            prev_err     <= '0;
            integral     <= '0;
            i_cand_r     <= '0;
            p_r          <= '0;
            d_r          <= '0;
            sum_r        <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sample_valid) begin
                        sp_r         <= setpoint;
                        fb_r         <= feedback;
                        kp_r         <= kp;
                        ki_r         <= ki;
                        kd_r         <= kd;
                        sample_ready <= 1'b0;
                        state        <= S_ERR;
                    end
                end
                S_ERR: begin
                    err_r <= $signed({1'b0, sp_r}) - $signed({1'b0, fb_r});
                    state <= S_TERMS;
                end
                S_TERMS: begin
                    p_r      <= p_x;
                    d_r      <= d_x;
                    i_cand_r <= i_sat;
                    state    <= S_SUM;
                end
                S_SUM: begin
                    sum_r <= sum_full >>> FRAC_BITS;
                    state <= S_OUT;
                end
                S_OUT: begin
                    control_out  <= out_clamped;
                    saturated    <= clip_hi || clip_lo;
                    out_valid    <= 1'b1;
                    prev_err     <= err_r;
                    if (!hold_int)
                        integral <= i_cand_r;
                    sample_ready <= 1'b1;
                    state        <= S_IDLE;
                end
                default: begin
                    sample_ready <= 1'b1;
                    state        <= S_IDLE;
                end
            endcase
            // placed last so it wins over a coincident OUT commit
            if (clear_int) begin
                integral <= '0;
                prev_err <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pid_ctrl_param.sv
// tb_pid_ctrl_param: directed bench for pid_ctrl_param with a cycle model
// of the controller's observable behaviour and hand-computed vectors.
module tb_pid_ctrl_param;

    localparam int DATA_W    = 8;
    localparam int COEF_W    = 8;
    localparam int FRAC_BITS = 4;
    localparam int ACC_W     = 24;
    localparam longint OMAX  = (longint'(1) << DATA_W) - 1;
    localparam longint ILIM  = (longint'(1) << (ACC_W-1)) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              sample_valid = 1'b0;
    logic              sample_ready;
    logic [DATA_W-1:0] setpoint = '0, feedback = '0;
    logic [COEF_W-1:0] kp = '0, ki = '0, kd = '0;
    logic              clear_int = 1'b0;
    logic [DATA_W-1:0] control_out;
    logic              out_valid;
    logic              saturated;

    int checks = 0;
    int errors = 0;

    pid_ctrl_param #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC_BITS(FRAC_BITS), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .setpoint(setpoint), .feedback(feedback),
        .kp(kp), .ki(ki), .kd(kd), .clear_int(clear_int),
        .control_out(control_out), .out_valid(out_valid), .saturated(saturated)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        longint e;
        longint ic;
        longint s;
    } terms_t;

    function automatic terms_t model_terms(input longint sp, fb, gp, gi, gd, integ, prev);
        terms_t t;
        t.e  = sp - fb;
        t.ic = integ + gi * t.e;
        if (t.ic > ILIM)  t.ic = ILIM;
        if (t.ic < -ILIM) t.ic = -ILIM;
        t.s  = (gp * t.e + t.ic + gd * (t.e - prev)) >>> FRAC_BITS;
        return t;
    endfunction

    int     m_cnt = 0;          // cycles since acceptance, 0 = idle
    longint l_sp = 0, l_fb = 0, l_kp = 0, l_ki = 0, l_kd = 0;
    terms_t m_t = '{0, 0, 0};
    logic   m_ov = 1'b0, m_sat = 1'b0;
    longint m_out = 0, m_int = 0, m_prev = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0; m_ov <= 1'b0; m_sat <= 1'b0;
            m_out <= 0; m_int <= 0; m_prev <= 0;
        end else begin
            m_ov <= 1'b0;
            case (m_cnt)
                0: if (sample_valid) begin
                    l_sp <= setpoint; l_fb <= feedback;
                    l_kp <= kp; l_ki <= ki; l_kd <= kd;
                    m_cnt <= 1;
                end
                2: begin
                    m_t   <= model_terms(l_sp, l_fb, l_kp, l_ki, l_kd, m_int, m_prev);
                    m_cnt <= 3;
                end
                4: begin
                    m_ov   <= 1'b1;
                    m_out  <= (m_t.s < 0) ? 0 : (m_t.s > OMAX) ? OMAX : m_t.s;
                    m_sat  <= (m_t.s < 0) || (m_t.s > OMAX);
                    m_prev <= m_t.e;
                    if (!((m_t.s > OMAX && m_t.e > 0) || (m_t.s < 0 && m_t.e < 0)))
                        m_int <= m_t.ic;
                    m_cnt  <= 0;
                end
                default: m_cnt <= m_cnt + 1;
            endcase
            if (clear_int) begin
                m_int  <= 0;
                m_prev <= 0;
            end
        end
    end

    // cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        chk("m_ready", sample_ready, (m_cnt == 0) ? 1 : 0);
        chk("m_valid", out_valid, m_ov);
        chk("m_ctrl", control_out, 32'(m_out));
        chk("m_sat", saturated, m_sat);
    end

    // ---------------- directed stimulus ----------------
    int got, gsat, lat;

    task automatic send(input logic [7:0] sp, fb, gp, gi, gd,
                        output int o_val, output int o_sat, output int o_lat);
        int n;
        n = 0;
        while (!sample_ready && n < 20) begin @(negedge clk); n++; end
        chk("ready_wait", sample_ready, 1);
        setpoint = sp; feedback = fb; kp = gp; ki = gi; kd = gd;
        sample_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
        // scramble inputs: the accepted sample must not see these
        setpoint = 8'($urandom); feedback = 8'($urandom);
        kp = 8'($urandom); ki = 8'($urandom); kd = 8'($urandom);
        o_lat = 1;
        while (!out_valid && o_lat < 20) begin @(negedge clk); o_lat++; end
        chk("out_valid_seen", out_valid, 1);
        o_val = control_out;
        o_sat = saturated;
    endtask

    task automatic pulse_clear();
        clear_int = 1'b1;
        @(negedge clk);
        clear_int = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, first_at, second_at;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", control_out, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_sat", saturated, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", sample_ready, 1);

        // proportional: 2.0 * 40 = 80, latency 5
        send(100, 60, 32, 0, 0, got, gsat, lat);
        chk("p_val", got, 80); chk("p_sat", gsat, 0); chk("p_lat", lat, 5);
        // clamp high / low
        send(255, 0, 32, 0, 0, got, gsat, lat);
        chk("hi_val", got, 255); chk("hi_sat", gsat, 1);
        send(10, 200, 32, 0, 0, got, gsat, lat);
        chk("lo_val", got, 0); chk("lo_sat", gsat, 1);

        // integral accumulates 10 per sample, clear restarts it
        pulse_clear();
        send(20, 10, 0, 16, 0, got, gsat, lat); chk("i1", got, 10);
        send(20, 10, 0, 16, 0, got, gsat, lat); chk("i2", got, 20);
        send(20, 10, 0, 16, 0, got, gsat, lat); chk("i3", got, 30);
        pulse_clear();
        send(20, 10, 0, 16, 0, got, gsat, lat); chk("i_clr", got, 10);

        // derivative: step then flat
        pulse_clear();
        send(20, 10, 0, 0, 16, got, gsat, lat); chk("d1", got, 10);
        send(20, 10, 0, 0, 16, got, gsat, lat); chk("d2", got, 0);

        // anti-windup: saturated high repeatedly, then reverse
        pulse_clear();
        for (int k = 0; k < 3; k++) begin
            send(255, 0, 0, 255, 0, got, gsat, lat);
            chk("aw_hi", got, 255); chk("aw_hi_sat", gsat, 1);
        end
        send(0, 255, 0, 255, 0, got, gsat, lat);
        chk("aw_rev", got, 0);

        // reset during TERMS abandons the sample
        pulse_clear();
        send(20, 10, 0, 16, 0, got, gsat, lat); chk("pre_rst", got, 10);
        setpoint = 20; feedback = 10; kp = 0; ki = 16; kd = 0;
        sample_valid = 1'b1;
        @(posedge clk);              // accepted
        @(posedge clk);              // now in TERMS
        #2 rst_n = 1'b0;
        sample_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_ctrl", control_out, 0);
        chk("mid_rst_sat", saturated, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        chk("rst_no_valid", pulses, 0);
        send(20, 10, 0, 16, 0, got, gsat, lat); chk("post_rst", got, 10);

        // sample_valid held high: one acceptance per 5 cycles
        pulse_clear();
        setpoint = 100; feedback = 60; kp = 32; ki = 0; kd = 0;
        sample_valid = 1'b1;
        pulses = 0; first_at = 0; second_at = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (out_valid) begin
                pulses++;
                if (pulses == 1) first_at = k;
                if (pulses == 2) second_at = k;
                chk("stream_val", control_out, 80);
            end
        end
        sample_valid = 1'b0;
        chk("stream_cnt", pulses, 3);
        chk("stream_first", first_at, 5);
        chk("stream_gap", second_at - first_at, 5);
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
